fixed_mul_nb: RTL



---
 rtl/fixed_mul_nb_if.sv | 33 +++
 rtl/fixed_mul_nb.sv | 98 +++++++++
 2 files changed

// File: rtl/fixed_mul_nb_if.sv
// fixed_mul_nb_if: request/result bundle for the shift-and-add fixed-point
// multiplier.
//   multiplicand  WIDTH-bit unsigned integer operand
//   factor        STEPS-bit unsigned fraction (value = factor / 2^STEPS)
//   din_valid     request strobe from the master
//   din_ready     multiplier is idle and will take the request
//   product       rounded result, held until the next result
//   dout_valid    one-cycle pulse when product updates
// Handshake: a request transfers on a rising edge where din_valid and
// din_ready are both high. din_valid while din_ready is low is dropped, not
// queued. There is no result back-pressure: dout_valid is a single-cycle
// strobe and product stays stable afterwards until the next result.
interface fixed_mul_nb_if #(
   parameter int WIDTH = 8,
   parameter int STEPS = 8
);
   logic [WIDTH-1:0] multiplicand;
   logic [STEPS-1:0] factor;
   logic             din_valid;
   logic             din_ready;
   logic [WIDTH-1:0] product;
   logic             dout_valid;

   modport master (
      output multiplicand, factor, din_valid,
      input  din_ready, product, dout_valid
   );

   modport slave (
      input  multiplicand, factor, din_valid,
      output din_ready, product, dout_valid
   );
endinterface

// File: rtl/fixed_mul_nb.sv
// fixed_mul_nb: multi-cycle unsigned fixed-point multiplier.
// Computes round_half_up(multiplicand * factor / 2^STEPS) by examining one
// factor bit per cycle (shift-and-add), so no multiplier cell is needed.
// One operation in flight; latency STEPS+1 edges from accept to dout_valid.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus        fixed_mul_nb_if slave modport (request in, result out)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
module fixed_mul_nb #(
   parameter int WIDTH = 8,
   parameter int STEPS = 8
) (
   input  logic                clk,
   input  logic                rst,
   fixed_mul_nb_if.slave       bus,
   output logic [1:0]          state_dbg
);

   localparam int AW = WIDTH + STEPS;
   localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);
   // Adding half an output LSB up front turns the final truncation into
   // round-half-up.
   localparam logic [AW-1:0] ROUND_K = AW'(1) << (STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] m_r;
   logic [STEPS-1:0] f_r;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic [AW-1:0]    m_ext;

   assign bus.din_ready = (state == S_IDLE);
   assign accept        = bus.din_valid && (state == S_IDLE);
   assign state_dbg     = state;
   assign m_ext         = AW'(m_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_RUN;
         S_RUN:  if (cnt == LAST_STEP) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_r            <= '0;
         f_r            <= '0;
         acc            <= '0;
         cnt            <= '0;
         bus.product    <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         bus.dout_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  m_r <= bus.multiplicand;
                  f_r <= bus.factor;
                  acc <= ROUND_K;
                  cnt <= '0;
               end
            end
            S_RUN: begin
               // Partial product for weight 2^cnt; the sum cannot overflow AW.
               if (f_r[cnt]) acc <= acc + (m_ext << cnt);
               cnt <= cnt + 1'b1;
            end
            S_DONE: begin
               bus.product    <= acc[AW-1:STEPS];
               bus.dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
